// File: rtl/pc_fetch_stage_pkg.sv
// Shared types and constants for the OTTER fetch stage.
package otter_fetch_pkg;

  localparam int unsigned INSTR_BYTES = 32'd4;

  // Next-PC source encodings driven by the branch/hazard logic.
  typedef enum logic [2:0] {
    PC4    = 3'd0,
    JALR   = 3'd1,
    BRANCH = 3'd2,
    JAL    = 3'd3,
    MTVEC  = 3'd4,
    MEPC   = 3'd5
  } pc_src_t;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_TRAP = 2'd2
  } fetch_state_t;

  // A target is usable only when word aligned.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage output bundle: IMEM request side plus the IF/ID fields.
interface pc_fetch_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] imem_addr;
  logic            imem_rden;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc4;
  logic            if_valid;
  logic            misalign;
  logic [XLEN-1:0] misalign_addr;

  modport master (
    output imem_addr, imem_rden, if_pc, if_pc4, if_valid, misalign, misalign_addr
  );
  modport slave (
    input imem_addr, imem_rden, if_pc, if_pc4, if_valid, misalign, misalign_addr
  );
endinterface

// File: rtl/pc_fetch_stage_next_pc_sel.sv
// Combinational next-PC priority select with jump/branch alignment check.
module next_pc_sel
  import otter_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_pc_source,
  input  logic            i_flush,
  input  logic            i_stall,
  input  logic            i_in_trap,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_jalr,
  input  logic [XLEN-1:0] i_branch,
  input  logic [XLEN-1:0] i_jal,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  output logic [XLEN-1:0] o_next_pc,
  output logic [XLEN-1:0] o_target,
  output logic            o_load,
  output logic            o_misaligned,
  output logic            o_trap_redir,
  output logic            o_jump_redir
);

  pc_src_t w_src;
  assign w_src = pc_src_t'(i_pc_source);

  // Decode the source select into a target and its redirect class; 6/7 fall to PC+4.
  always_comb begin
    o_target     = '0;
    o_trap_redir = 1'b0;
    o_jump_redir = 1'b0;
    case (w_src)
      JALR:    begin o_target = i_jalr;   o_jump_redir = 1'b1; end
      BRANCH:  begin o_target = i_branch; o_jump_redir = 1'b1; end
      JAL:     begin o_target = i_jal;    o_jump_redir = 1'b1; end
      MTVEC:   begin o_target = i_mtvec;  o_trap_redir = 1'b1; end
      MEPC:    begin o_target = i_mepc;   o_trap_redir = 1'b1; end
      default: begin o_target = '0; end
    endcase
  end

  // Priority: trap redirect > trap hold > flush > jump/branch > stall > PC+4.
  always_comb begin
    o_next_pc    = i_pc + XLEN'(INSTR_BYTES);
    o_load       = 1'b0;
    o_misaligned = 1'b0;
    if (o_trap_redir) begin
      o_next_pc = o_target;
      o_load    = 1'b1;
    end else if (i_in_trap || i_flush) begin
      o_load = 1'b0;
    end else if (o_jump_redir) begin
      if (is_misaligned(o_target[1:0])) begin
        o_misaligned = 1'b1;
      end else begin
        o_next_pc = o_target;
        o_load    = 1'b1;
      end
    end else if (i_stall) begin
      o_load = 1'b0;
    end else begin
      o_load = 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// OTTER fetch stage: PC register, boot/run/trap FSM, IF/ID registers, fetch counter.
module pc_fetch_stage
  import otter_fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic [2:0]       i_pc_source,
  input  logic [XLEN-1:0]  i_jalr,
  input  logic [XLEN-1:0]  i_branch,
  input  logic [XLEN-1:0]  i_jal,
  input  logic [XLEN-1:0]  i_mtvec,
  input  logic [XLEN-1:0]  i_mepc,
  pc_fetch_if.master       o_fetch,
  output logic [CNT_W-1:0] o_fetch_cnt
);

  fetch_state_t    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, r_if_pc, r_if_pc4, r_misalign_addr;
  logic            r_if_valid, r_misalign;
  logic [CNT_W-1:0] r_fetch_cnt;

  logic [XLEN-1:0] w_next_pc, w_target;
  logic            w_load, w_misaligned, w_trap_redir, w_jump_redir;
  logic            w_in_trap, w_rden, w_kill;

  next_pc_sel #(.XLEN(XLEN)) u_sel (
    .i_pc_source (i_pc_source),
    .i_flush     (i_flush),
    .i_stall     (i_stall),
    .i_in_trap   (w_in_trap),
    .i_pc        (r_pc),
    .i_jalr      (i_jalr),
    .i_branch    (i_branch),
    .i_jal       (i_jal),
    .i_mtvec     (i_mtvec),
    .i_mepc      (i_mepc),
    .o_next_pc   (w_next_pc),
    .o_target    (w_target),
    .o_load      (w_load),
    .o_misaligned(w_misaligned),
    .o_trap_redir(w_trap_redir),
    .o_jump_redir(w_jump_redir)
  );

  // Any redirect or flush means the fetch in flight is not a live instruction.
  assign w_kill = w_trap_redir | w_jump_redir | i_flush;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a bad jump target traps; only a trap redirect leaves the trap.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT, S_RUN: w_state_nxt = w_misaligned ? S_TRAP : S_RUN;
      S_TRAP:        w_state_nxt = w_trap_redir ? S_RUN : S_TRAP;
      default:       w_state_nxt = S_BOOT;
    endcase
  end

  // FSM outputs: fetch enable and trap indication.
  always_comb begin
    w_rden    = 1'b0;
    w_in_trap = 1'b0;
    case (r_state)
      S_BOOT, S_RUN: begin w_rden = ~i_rst & ~i_stall; w_in_trap = 1'b0; end
      S_TRAP:        begin w_rden = 1'b0;              w_in_trap = 1'b1; end
      default:       begin w_rden = 1'b0;              w_in_trap = 1'b0; end
    endcase
  end

  // PC register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= RESET_VEC;
    end else if (w_load) begin
      r_pc <= w_next_pc;
    end else begin
      r_pc <= r_pc;
    end
  end

  // IF/ID registers track the address fetched last cycle, aligned with IMEM data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_if_pc    <= RESET_VEC;
      r_if_pc4   <= RESET_VEC + XLEN'(INSTR_BYTES);
      r_if_valid <= 1'b0;
    end else if (w_in_trap || w_kill) begin
      r_if_valid <= 1'b0;
    end else if (i_stall) begin
      r_if_valid <= r_if_valid;
    end else begin
      r_if_pc    <= r_pc;
      r_if_pc4   <= r_pc + XLEN'(INSTR_BYTES);
      r_if_valid <= 1'b1;
    end
  end

  // Misaligned-target trap request and captured address.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
    end else if (w_in_trap && w_trap_redir) begin
      r_misalign <= 1'b0;
    end else if (!w_in_trap && w_misaligned) begin
      r_misalign      <= 1'b1;
      r_misalign_addr <= w_target;
    end else begin
      r_misalign <= r_misalign;
    end
  end

  // Count live instructions actually consumed (not held by a stall).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_cnt <= '0;
    end else if (r_if_valid && !i_stall) begin
      r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
    end else begin
      r_fetch_cnt <= r_fetch_cnt;
    end
  end

  assign o_fetch.imem_addr     = r_pc;
  assign o_fetch.imem_rden     = w_rden;
  assign o_fetch.if_pc         = r_if_pc;
  assign o_fetch.if_pc4        = r_if_pc4;
  assign o_fetch.if_valid      = r_if_valid;
  assign o_fetch.misalign      = r_misalign;
  assign o_fetch.misalign_addr = r_misalign_addr;
  assign o_fetch_cnt           = r_fetch_cnt;

endmodule
